// File: rtl/img_rsz_blk_accum_pkg.sv
// Shared types and the per-pixel block reduction for the resize block accumulator.
// Pixel and block-value widths live here so every file agrees on them.
package img_rsz_blk_accum_pkg;

    localparam int PXL_PRIM_COLOR_NUM  = 1;
    localparam int PXL_PRIM_COLOR_W    = 8;
    localparam int BLK_WIDTH_MAX_SZ_W  = 7;
    localparam int BLK_HEIGHT_MAX_SZ_W = 7;
    localparam int BLK_SUM_MAX_W       = PXL_PRIM_COLOR_W + BLK_WIDTH_MAX_SZ_W + BLK_HEIGHT_MAX_SZ_W;

    typedef logic [BLK_WIDTH_MAX_SZ_W:0]  BlkCnt_t;
    typedef logic [BLK_HEIGHT_MAX_SZ_W:0] BlkHCnt_t;
    typedef logic [PXL_PRIM_COLOR_W-1:0]  PrimColor_t;
    typedef logic [BLK_SUM_MAX_W-1:0]     BlkVal_t;

    typedef PrimColor_t [PXL_PRIM_COLOR_NUM-1:0] FcRszPxlData_t;
    typedef BlkVal_t    [PXL_PRIM_COLOR_NUM-1:0] FcBlkVal_t;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN} RszState_t;

    // Running sum for average pooling, running unsigned max for max pooling.
    function automatic BlkVal_t blk_op(input logic is_max, input BlkVal_t acc, input PrimColor_t pxl);
        BlkVal_t ext;
        ext = BlkVal_t'(pxl);
        if (is_max) return (ext > acc) ? ext : acc;
        return acc + ext;
    endfunction

endpackage

// File: rtl/img_rsz_blk_accum_acc_lane.sv
// One colour lane of one block column: restarts on the first pixel of a block,
// otherwise folds each accepted pixel into the running block value.
module img_rsz_acc_lane
    import img_rsz_blk_accum_pkg::*;
#(
    parameter bit IS_MAX = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       init_i,
    input  PrimColor_t pxl_i,
    output BlkVal_t    acc_o
);

    BlkVal_t acc_q;
    BlkVal_t acc_d;

    // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
    always_comb begin
        acc_d = acc_q;
        if (en_i) acc_d = init_i ? BlkVal_t'(pxl_i) : blk_op(IS_MAX, acc_q, pxl_i);
    end

    // NOTE: the accumulator row is plain flops, so it takes the async reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/img_rsz_blk_accum.sv
// Block accumulator: folds a raster pixel stream into one block-row of sums/maxima,
// then drains that row to the divider stage before accepting the next block-row.
module img_rsz_blk_accum
    import img_rsz_blk_accum_pkg::*;
#(
    parameter          RSZ_ALGORITHM        = "AVR-POOLING",
    parameter int      RSZ_IMG_WIDTH_SIZE   = 8,
    parameter int      RSZ_IMG_HEIGHT_SIZE  = 8,
    localparam int     RSZ_IMG_WIDTH_IDX_W  = (RSZ_IMG_WIDTH_SIZE  > 1) ? $clog2(RSZ_IMG_WIDTH_SIZE)  : 1,
    localparam int     RSZ_IMG_HEIGHT_IDX_W = (RSZ_IMG_HEIGHT_SIZE > 1) ? $clog2(RSZ_IMG_HEIGHT_SIZE) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [BLK_WIDTH_MAX_SZ_W:0]     cfg_blk_w,
    input  logic [BLK_HEIGHT_MAX_SZ_W:0]    cfg_blk_h,
    input  logic                            pxl_vld,
    input  FcRszPxlData_t                   pxl_data,
    output logic                            pxl_rdy,
    output logic                            blk_vld,
    output FcBlkVal_t                       blk_val,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  blk_col,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] blk_row,
    output logic                            blk_last,
    input  logic                            blk_rdy,
    output logic                            busy
);

    localparam bit IS_MAX = (RSZ_ALGORITHM == "MAX-POOLING");
    localparam logic [RSZ_IMG_WIDTH_IDX_W-1:0]  COL_LAST = RSZ_IMG_WIDTH_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1);
    localparam logic [RSZ_IMG_HEIGHT_IDX_W-1:0] ROW_LAST = RSZ_IMG_HEIGHT_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1);

    RszState_t                       state_q, state_d;
    BlkCnt_t                         x_q, x_d, cfg_w_q, cfg_w_d;
    BlkHCnt_t                        y_q, y_d, cfg_h_q, cfg_h_d;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  col_q, col_d;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] row_q, row_d;

    logic pxl_hs, blk_hs, x_last, y_last, col_last, row_last, blk_first;

    assign pxl_hs    = (state_q == ACC)   && pxl_vld;
    assign blk_hs    = (state_q == DRAIN) && blk_rdy;
    assign x_last    = (x_q == (cfg_w_q - 1'b1));
    assign y_last    = (y_q == (cfg_h_q - 1'b1));
    assign col_last  = (col_q == COL_LAST);
    assign row_last  = (row_q == ROW_LAST);
    assign blk_first = (x_q == '0) && (y_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cfg_w_q <= '0;
            cfg_h_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cfg_w_q <= cfg_w_d;
            cfg_h_q <= cfg_h_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ACC;
            ACC:     if (pxl_hs && x_last && col_last && y_last) state_d = DRAIN;
            DRAIN:   if (blk_hs && col_last) state_d = row_last ? IDLE : ACC;
            default: state_d = IDLE;
        endcase
    end

    // Block geometry counters; col doubles as the drain pointer.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        row_d   = row_q;
        cfg_w_d = cfg_w_q;
        cfg_h_d = cfg_h_q;
        unique case (state_q)
            IDLE: if (start) begin
                cfg_w_d = (cfg_blk_w == '0) ? BlkCnt_t'(1)  : cfg_blk_w;
                cfg_h_d = (cfg_blk_h == '0) ? BlkHCnt_t'(1) : cfg_blk_h;
                x_d     = '0;
                y_d     = '0;
                col_d   = '0;
                row_d   = '0;
            end
            ACC: if (pxl_hs) begin
                if (x_last) begin
                    x_d = '0;
                    if (col_last) begin
                        col_d = '0;
                        y_d   = y_last ? '0 : y_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            DRAIN: if (blk_hs) begin
                if (col_last) begin
                    col_d = '0;
                    row_d = row_last ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    BlkVal_t lane_acc [RSZ_IMG_WIDTH_SIZE][PXL_PRIM_COLOR_NUM];

    for (genvar g_col = 0; g_col < RSZ_IMG_WIDTH_SIZE; g_col++) begin : g_col_lanes
        logic lane_en;
        assign lane_en = pxl_hs && (col_q == RSZ_IMG_WIDTH_IDX_W'(g_col));
        for (genvar g_clr = 0; g_clr < PXL_PRIM_COLOR_NUM; g_clr++) begin : g_clr_lanes
            img_rsz_acc_lane #(.IS_MAX(IS_MAX)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .en_i   (lane_en),
                .init_i (blk_first),
                .pxl_i  (pxl_data[g_clr]),
                .acc_o  (lane_acc[g_col][g_clr])
            );
        end
    end

    // Outputs are decoded from registered state only, so blk_vld never depends on blk_rdy.
    always_comb begin
        pxl_rdy  = (state_q == ACC);
        busy     = (state_q != IDLE);
        blk_vld  = (state_q == DRAIN);
        blk_col  = '0;
        blk_row  = '0;
        blk_last = 1'b0;
        blk_val  = '0;
        if (state_q == DRAIN) begin
            blk_col  = col_q;
            blk_row  = row_q;
            blk_last = col_last && row_last;
            for (int i = 0; i < RSZ_IMG_WIDTH_SIZE; i++) begin
                if (col_q == RSZ_IMG_WIDTH_IDX_W'(i)) begin
                    for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) blk_val[c] = lane_acc[i][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_img_rsz_blk_accum.sv
// Directed bench for the block accumulator: average, max and single-block builds,
// with back-pressure, input gaps and reset in the middle of a frame.
module tb_img_rsz_blk_accum;
    import img_rsz_blk_accum_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    start_v = '0;
    BlkCnt_t       cfg_w = '0;
    BlkHCnt_t      cfg_h = '0;
    logic          pxl_vld = 1'b0;
    FcRszPxlData_t pxl_data = '0;
    logic          blk_rdy = 1'b0;

    logic pxl_rdy_a, blk_vld_a, blk_last_a, busy_a;
    logic pxl_rdy_m, blk_vld_m, blk_last_m, busy_m;
    logic pxl_rdy_b, blk_vld_b, blk_last_b, busy_b;
    FcBlkVal_t blk_val_a, blk_val_m, blk_val_b;
    logic [2:0] blk_col_a, blk_row_a, blk_col_m, blk_row_m;
    logic       blk_col_b, blk_row_b;

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int pix[];
    int exp_v[];

    logic       cur_pxl_rdy, cur_blk_vld, cur_blk_last, cur_busy;
    FcBlkVal_t  cur_blk_val;
    logic [2:0] cur_col, cur_row;

    always #5 clk = ~clk;

    img_rsz_blk_accum #(.RSZ_ALGORITHM("AVR-POOLING"), .RSZ_IMG_WIDTH_SIZE(8), .RSZ_IMG_HEIGHT_SIZE(8)) u_avr (
        .clk(clk), .rst(rst), .start(start_v[0]), .cfg_blk_w(cfg_w), .cfg_blk_h(cfg_h),
        .pxl_vld(pxl_vld), .pxl_data(pxl_data), .pxl_rdy(pxl_rdy_a), .blk_vld(blk_vld_a),
        .blk_val(blk_val_a), .blk_col(blk_col_a), .blk_row(blk_row_a), .blk_last(blk_last_a),
        .blk_rdy(blk_rdy), .busy(busy_a));

    img_rsz_blk_accum #(.RSZ_ALGORITHM("MAX-POOLING"), .RSZ_IMG_WIDTH_SIZE(8), .RSZ_IMG_HEIGHT_SIZE(8)) u_max (
        .clk(clk), .rst(rst), .start(start_v[1]), .cfg_blk_w(cfg_w), .cfg_blk_h(cfg_h),
        .pxl_vld(pxl_vld), .pxl_data(pxl_data), .pxl_rdy(pxl_rdy_m), .blk_vld(blk_vld_m),
        .blk_val(blk_val_m), .blk_col(blk_col_m), .blk_row(blk_row_m), .blk_last(blk_last_m),
        .blk_rdy(blk_rdy), .busy(busy_m));

    // Single-block image keeps the 128x128 case within a short run.
    img_rsz_blk_accum #(.RSZ_ALGORITHM("AVR-POOLING"), .RSZ_IMG_WIDTH_SIZE(1), .RSZ_IMG_HEIGHT_SIZE(1)) u_big (
        .clk(clk), .rst(rst), .start(start_v[2]), .cfg_blk_w(cfg_w), .cfg_blk_h(cfg_h),
        .pxl_vld(pxl_vld), .pxl_data(pxl_data), .pxl_rdy(pxl_rdy_b), .blk_vld(blk_vld_b),
        .blk_val(blk_val_b), .blk_col(blk_col_b), .blk_row(blk_row_b), .blk_last(blk_last_b),
        .blk_rdy(blk_rdy), .busy(busy_b));

    always_comb begin
        cur_pxl_rdy  = pxl_rdy_a;
        cur_blk_vld  = blk_vld_a;
        cur_blk_val  = blk_val_a;
        cur_col      = blk_col_a;
        cur_row      = blk_row_a;
        cur_blk_last = blk_last_a;
        cur_busy     = busy_a;
        case (sel)
            1: begin
                cur_pxl_rdy = pxl_rdy_m; cur_blk_vld = blk_vld_m; cur_blk_val = blk_val_m;
                cur_col = blk_col_m; cur_row = blk_row_m; cur_blk_last = blk_last_m; cur_busy = busy_m;
            end
            2: begin
                cur_pxl_rdy = pxl_rdy_b; cur_blk_vld = blk_vld_b; cur_blk_val = blk_val_b;
                cur_col = {2'b00, blk_col_b}; cur_row = {2'b00, blk_row_b};
                cur_blk_last = blk_last_b; cur_busy = busy_b;
            end
            default: ;
        endcase
    end

    // Reference block values from the stored frame.
    task automatic model(input int nbw, input int nbh, input int w, input int h, input bit is_max);
        int b;
        exp_v = new[nbw * nbh];
        foreach (exp_v[i]) exp_v[i] = 0;
        for (int y = 0; y < nbh * h; y++)
            for (int x = 0; x < nbw * w; x++) begin
                b = (y / h) * nbw + (x / w);
                if (is_max) begin
                    if (pix[y * nbw * w + x] > exp_v[b]) exp_v[b] = pix[y * nbw * w + x];
                end else begin
                    exp_v[b] += pix[y * nbw * w + x];
                end
            end
    endtask

    // Streams pix[] into DUT s while collecting and checking every drained block against exp_v[].
    task automatic run_frame(input int s, input int cw, input int ch, input bit gaps, input bit rnd_rdy,
                             input bit poke_start);
        int nbw, npix, nbeats, idx, fcyc, beat, ccyc, budget;
        logic       prev_stall;
        FcBlkVal_t  prev_val;
        logic [2:0] prev_col, prev_row;
        logic       prev_last;
        nbw    = (s == 2) ? 1 : 8;
        npix   = pix.size();
        nbeats = exp_v.size();
        budget = npix * 8 + 4000;
        sel    = s;
        @(negedge clk);
        cfg_w      = BlkCnt_t'(cw);
        cfg_h      = BlkHCnt_t'(ch);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v = '0;
        cfg_w   = BlkCnt_t'(7);
        cfg_h   = BlkHCnt_t'(2);
        total++;
        if (cur_busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy dut=%0d got=%b want=1", s, cur_busy);
        end
        fork
            begin
                idx = 0;
                fcyc = 0;
                while (idx < npix && fcyc < budget) begin
                    @(negedge clk);
                    fcyc++;
                    start_v = '0;
                    if (poke_start && idx == 5) begin
                        cfg_w      = BlkCnt_t'(3);
                        start_v[s] = 1'b1;
                    end
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        pxl_vld = 1'b0;
                    end else begin
                        pxl_vld     = 1'b1;
                        pxl_data[0] = PrimColor_t'(pix[idx]);
                    end
                    if (pxl_vld && cur_pxl_rdy) idx++;
                end
                @(negedge clk);
                pxl_vld = 1'b0;
                start_v = '0;
                if (idx < npix) begin
                    total++;
                    bad++;
                    $display("FAIL pxl_timeout dut=%0d sent=%0d want=%0d", s, idx, npix);
                end
            end
            begin
                beat = 0;
                ccyc = 0;
                prev_stall = 1'b0;
                prev_val = '0; prev_col = '0; prev_row = '0; prev_last = 1'b0;
                while (beat < nbeats && ccyc < budget) begin
                    @(negedge clk);
                    ccyc++;
                    if (prev_stall) begin
                        total++;
                        if ({cur_blk_vld, cur_blk_val, cur_col, cur_row, cur_blk_last} !==
                            {1'b1, prev_val, prev_col, prev_row, prev_last}) begin
                            bad++;
                            $display("FAIL stall_stable dut=%0d beat=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                                     s, beat, cur_blk_val[0], cur_col, cur_row, prev_val[0], prev_col, prev_row);
                        end
                    end
                    blk_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (cur_blk_vld) begin
                        total++;
                        if (cur_pxl_rdy !== 1'b0) begin
                            bad++;
                            $display("FAIL drain_pxl_rdy dut=%0d beat=%0d got=%b want=0", s, beat, cur_pxl_rdy);
                        end
                        if (blk_rdy) begin
                            total++;
                            if (cur_blk_val[0] !== BlkVal_t'(exp_v[beat])) begin
                                bad++;
                                $display("FAIL blk_val dut=%0d beat=%0d got=%0d want=%0d",
                                         s, beat, cur_blk_val[0], exp_v[beat]);
                            end
                            total++;
                            if ({cur_col, cur_row, cur_blk_last} !==
                                {3'(beat % nbw), 3'(beat / nbw), (beat == nbeats - 1)}) begin
                                bad++;
                                $display("FAIL blk_pos dut=%0d beat=%0d got col=%0d row=%0d last=%b want col=%0d row=%0d last=%b",
                                         s, beat, cur_col, cur_row, cur_blk_last, beat % nbw, beat / nbw,
                                         (beat == nbeats - 1));
                            end
                            beat++;
                        end
                    end
                    prev_stall = cur_blk_vld && !blk_rdy;
                    prev_val = cur_blk_val; prev_col = cur_col; prev_row = cur_row; prev_last = cur_blk_last;
                end
                if (beat < nbeats) begin
                    total++;
                    bad++;
                    $display("FAIL blk_timeout dut=%0d beats=%0d want=%0d", s, beat, nbeats);
                end
            end
        join
        @(negedge clk);
        blk_rdy = 1'b0;
        total++;
        if ({cur_busy, cur_blk_vld, cur_pxl_rdy} !== 3'b000) begin
            bad++;
            $display("FAIL frame_end_idle dut=%0d got busy/vld/rdy=%b%b%b want=000",
                     s, cur_busy, cur_blk_vld, cur_pxl_rdy);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({pxl_rdy_a, blk_vld_a, busy_a, blk_last_a, blk_col_a, blk_row_a, blk_val_a} !== '0) begin
            bad++;
            $display("FAIL reset_avr got rdy=%b vld=%b busy=%b val=%0d want all 0",
                     pxl_rdy_a, blk_vld_a, busy_a, blk_val_a[0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy_a, busy_m, busy_b, pxl_rdy_m, pxl_rdy_b, blk_vld_m, blk_vld_b} !== '0) begin
            bad++;
            $display("FAIL reset_all got busy=%b%b%b want 000", busy_a, busy_m, busy_b);
        end
    endtask

    task automatic test_1x1_index();
        pix   = new[64];
        exp_v = new[64];
        foreach (pix[i]) begin
            pix[i]   = i;
            exp_v[i] = i;
        end
        run_frame(0, 1, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_2x2_sat();
        pix   = new[256];
        exp_v = new[64];
        foreach (pix[i])   pix[i]   = 255;
        foreach (exp_v[i]) exp_v[i] = 1020;
        run_frame(0, 2, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_128_no_wrap();
        pix   = new[128 * 128];
        exp_v = new[1];
        foreach (pix[i]) pix[i] = 255;
        exp_v[0] = 4177920;
        run_frame(2, 128, 128, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_pressure_3x5();
        pix = new[24 * 40];
        foreach (pix[i]) pix[i] = int'($urandom_range(0, 255));
        model(8, 8, 3, 5, 1'b0);
        run_frame(0, 3, 5, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_max_4x4();
        pix   = new[32 * 32];
        exp_v = new[64];
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) pix[y * 32 + x] = (x + y) % 256;
        // Largest x+y in block (r,c) is (4c+3)+(4r+3).
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) exp_v[r * 8 + c] = 4 * (r + c) + 6;
        run_frame(1, 4, 4, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        int beats, cyc, after;
        beats = 0; cyc = 0; after = 0;
        sel = 0;
        @(negedge clk);
        cfg_w = BlkCnt_t'(1);
        cfg_h = BlkHCnt_t'(1);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v = '0;
        blk_rdy = 1'b1;
        // Three block-rows drained (24 beats), then three pixels into block-row 3.
        while (after < 3 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            pxl_vld     = 1'b1;
            pxl_data[0] = PrimColor_t'(cyc);
            if (blk_vld_a && blk_rdy) beats++;
            else if (beats >= 24 && pxl_rdy_a) after++;
        end
        total++;
        if ({busy_a, pxl_rdy_a, 2'(after == 3 ? 3 : 0)} !== 4'b1111) begin
            bad++;
            $display("FAIL mid_row3_acc got busy=%b rdy=%b after=%0d beats=%0d want busy=1 rdy=1 after=3",
                     busy_a, pxl_rdy_a, after, beats);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({pxl_rdy_a, blk_vld_a, busy_a, blk_last_a, blk_col_a, blk_row_a, blk_val_a} !== '0) begin
            bad++;
            $display("FAIL mid_reset_async got rdy=%b vld=%b busy=%b want all 0", pxl_rdy_a, blk_vld_a, busy_a);
        end
        @(posedge clk);
        #1;
        total++;
        if ({pxl_rdy_a, blk_vld_a, busy_a, blk_last_a, blk_col_a, blk_row_a, blk_val_a} !== '0) begin
            bad++;
            $display("FAIL mid_reset_next got rdy=%b vld=%b busy=%b val=%0d want all 0",
                     pxl_rdy_a, blk_vld_a, busy_a, blk_val_a[0]);
        end
        @(negedge clk);
        rst     = 1'b0;
        pxl_vld = 1'b0;
        blk_rdy = 1'b0;
        // Fresh frame with cfg 0x0 (acts as 1x1) and a stray start pulse while busy.
        pix = new[64];
        foreach (pix[i]) pix[i] = int'($urandom_range(0, 255));
        model(8, 8, 1, 1, 1'b0);
        run_frame(0, 0, 0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_1x1_index();
        test_2x2_sat();
        test_128_no_wrap();
        test_back_pressure_3x5();
        test_max_4x4();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
